// File: rtl/vic_vect_ctrl_pkg.sv
// ============================================================================
// Module  : vic_vect_ctrl_pkg
// Brief   : Shared sizes and control-field layout for the VIC vector controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vic_vect_ctrl_pkg;

    localparam int VIC_NUM_VECT  = 16;
    localparam int VIC_AW        = 32;
    localparam int VCNTL_EN_BIT  = 5;
    localparam int VCNTL_SRC_MSB = 4;
    localparam int VCNTL_W       = 6;

    // The non-vectored level sits just above the last vectored slot.
    function automatic int def_level(input int num_vect);
        return num_vect;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vic_prio_enc.sv
// ============================================================================
// Module  : vic_prio_enc
// Brief   : Lowest-set-bit encoder returning the bit index and a valid flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign valid = |vec;

endmodule

`default_nettype wire

// File: rtl/vic_vect_ctrl.sv
// ============================================================================
// Module  : vic_vect_ctrl
// Brief   : Fixed-priority vectored IRQ arbiter with nesting stack and VectAddr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_vect_ctrl
    import vic_vect_ctrl_pkg::*;
#(
    parameter int NUM_VECT = VIC_NUM_VECT,
    parameter int AW       = VIC_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             irq_status,
    input  logic [NUM_VECT*AW-1:0]  vect_addr_bus,
    input  logic [NUM_VECT*6-1:0]   vect_cntl_bus,
    input  logic [AW-1:0]           def_vect_addr,
    input  logic                    va_rd,
    input  logic                    va_wr,
    output logic [AW-1:0]           va_rdata,
    output logic                    irq,
    output logic [NUM_VECT:0]       in_service
);

    localparam int IW      = $clog2(NUM_VECT + 2);
    localparam int DEF_LVL = def_level(NUM_VECT);

    logic [NUM_VECT-1:0][VCNTL_W-1:0] slot_cntl;
    logic [NUM_VECT-1:0]              hits;
    logic [31:0]                      named;
    logic                             nonvect;
    logic [IW-1:0]                    hit_idx;
    logic                             hit_valid;
    logic [IW-1:0]                    ceil_idx;
    logic                             ceil_valid;
    logic [IW-1:0]                    ceiling;
    logic                             win_vect;
    logic                             win_def;
    logic                             win;
    logic [IW-1:0]                    win_idx;
    logic [IW-1:0]                    rd_lvl;
    logic [AW-1:0]                    rd_addr;
    logic [NUM_VECT:0]                push_mask;

    for (genvar n = 0; n < NUM_VECT; n++) begin : g_slot
        assign slot_cntl[n] = vect_cntl_bus[n*VCNTL_W +: VCNTL_W];
        assign hits[n]      = slot_cntl[n][VCNTL_EN_BIT]
                              && irq_status[slot_cntl[n][VCNTL_SRC_MSB:0]];
    end

    // Sources claimed by any enabled slot never count as non-vectored.
    always_comb begin
        named = '0;
        for (int n = 0; n < NUM_VECT; n++) begin
            if (slot_cntl[n][VCNTL_EN_BIT]) begin
                named[slot_cntl[n][VCNTL_SRC_MSB:0]] = 1'b1;
            end
        end
    end

    assign nonvect = |(irq_status & ~named);

    vic_prio_enc #(.WIDTH(NUM_VECT), .IW(IW)) u_hit_enc (
        .vec   (hits),
        .idx   (hit_idx),
        .valid (hit_valid)
    );

    vic_prio_enc #(.WIDTH(NUM_VECT + 1), .IW(IW)) u_ceil_enc (
        .vec   (in_service),
        .idx   (ceil_idx),
        .valid (ceil_valid)
    );

    assign ceiling  = ceil_valid ? ceil_idx : IW'(NUM_VECT + 1);
    assign win_vect = hit_valid && (hit_idx < ceiling);
    assign win_def  = !win_vect && nonvect && !ceil_valid;
    assign win      = win_vect || win_def;
    assign win_idx  = win_vect ? hit_idx : IW'(DEF_LVL);

    // Read returns the winner, else the current ceiling (re-read), else default.
    assign rd_lvl = win ? win_idx : (ceil_valid ? ceil_idx : IW'(DEF_LVL));

    always_comb begin
        rd_addr = def_vect_addr;
        for (int n = 0; n < NUM_VECT; n++) begin
            if (rd_lvl == IW'(n)) begin
                rd_addr = vect_addr_bus[n*AW +: AW];
            end
        end
    end

    assign push_mask = {{NUM_VECT{1'b0}}, 1'b1} << win_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_service <= '0;
            va_rdata   <= '0;
            irq        <= 1'b0;
        end else begin
            irq <= win;
            if (va_wr) begin
                in_service <= in_service & (in_service - (NUM_VECT + 1)'(1));
            end else if (va_rd) begin
                va_rdata <= rd_addr;
                if (win) begin
                    in_service <= in_service | push_mask;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vic_vect_ctrl.sv
// ============================================================================
// Module  : tb_vic_vect_ctrl
// Brief   : Directed and randomized bench for vic_vect_ctrl against a stack model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vic_vect_ctrl;

    localparam int NV = 16;
    localparam int AW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        irq_status;
    logic [NV*AW-1:0]   vect_addr_bus;
    logic [NV*6-1:0]    vect_cntl_bus;
    logic [AW-1:0]      def_vect_addr;
    logic               va_rd;
    logic               va_wr;
    logic [AW-1:0]      va_rdata;
    logic               irq;
    logic [NV:0]        in_service;

    always #5 clk = ~clk;

    vic_vect_ctrl #(.NUM_VECT(NV), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_status    (irq_status),
        .vect_addr_bus (vect_addr_bus),
        .vect_cntl_bus (vect_cntl_bus),
        .def_vect_addr (def_vect_addr),
        .va_rd         (va_rd),
        .va_wr         (va_wr),
        .va_rdata      (va_rdata),
        .irq           (irq),
        .in_service    (in_service)
    );

    // Reference state: slot table, nesting stack of levels, expected read data.
    logic [5:0]   m_cntl [NV];
    logic [AW-1:0] m_addr [NV];
    int           stk [$];
    logic [AW-1:0] exp_rdata;
    int           errors = 0;
    int           checks = 0;

    function automatic int model_winner();
        int  ceil;
        bit  named [32];
        ceil = (stk.size() == 0) ? NV + 1 : stk[$];
        for (int n = 0; n < NV; n++)
            if (m_cntl[n][5] && irq_status[m_cntl[n][4:0]] && n < ceil) return n;
        for (int s = 0; s < 32; s++) named[s] = 0;
        for (int n = 0; n < NV; n++)
            if (m_cntl[n][5]) named[m_cntl[n][4:0]] = 1;
        for (int s = 0; s < 32; s++)
            if (irq_status[s] && !named[s] && ceil == NV + 1) return NV;
        return -1;
    endfunction

    function automatic logic [AW-1:0] level_addr(input int lvl);
        return (lvl < NV) ? m_addr[lvl] : def_vect_addr;
    endfunction

    function automatic logic [NV:0] model_is();
        logic [NV:0] v = '0;
        foreach (stk[i]) v[stk[i]] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int n, input logic [5:0] c, input logic [AW-1:0] a);
        m_cntl[n] = c;
        m_addr[n] = a;
        vect_cntl_bus[n*6 +: 6]   = c;
        vect_addr_bus[n*AW +: AW] = a;
    endtask

    task automatic clear_slots();
        for (int n = 0; n < NV; n++) set_slot(n, 6'h00, 32'(n * 16 + 4));
    endtask

    // One clock with the given strobes; the model advances on the same edge.
    task automatic cycle(input bit rd, input bit wr);
        int w;
        if (wr) begin
            if (stk.size() != 0) void'(stk.pop_back());
        end else if (rd) begin
            w = model_winner();
            if (w >= 0) begin
                exp_rdata = level_addr(w);
                stk.push_back(w);
            end else if (stk.size() != 0) begin
                exp_rdata = level_addr(stk[$]);
            end else begin
                exp_rdata = def_vect_addr;
            end
        end
        va_rd = rd;
        va_wr = wr;
        @(negedge clk);
        va_rd = 1'b0;
        va_wr = 1'b0;
    endtask

    task automatic check(input string tag);
        cycle(0, 0);
        chk({tag, "_irq"}, 64'(irq), 64'(model_winner() >= 0));
        chk({tag, "_rdata"}, 64'(va_rdata), 64'(exp_rdata));
        chk({tag, "_insvc"}, 64'(in_service), 64'(model_is()));
    endtask

    initial begin
        rst = 1'b0;
        va_rd = 1'b1;
        va_wr = 1'b0;
        irq_status = '0;
        def_vect_addr = 32'hDEAD;
        vect_addr_bus = '0;
        vect_cntl_bus = '0;
        clear_slots();
        exp_rdata = '0;

        // Reset held with a read strobe asserted
        repeat (3) @(negedge clk);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_rdata", 64'(va_rdata), 64'd0);
        chk("rst_insvc", 64'(in_service), 64'd0);
        va_rd = 1'b0;
        rst = 1'b1;
        check("post_rst");

        // Single vector
        set_slot(3, 6'h25, 32'h100);
        irq_status = 32'h20;
        cycle(0, 0);
        chk("sv_irq_1cyc", 64'(irq), 64'd1);
        cycle(1, 0);
        check("sv_ack");
        chk("sv_rdata_lit", 64'(va_rdata), 64'h100);
        chk("sv_irq_lit", 64'(irq), 64'd0);
        cycle(0, 1);
        check("sv_eoi");
        chk("sv_reassert", 64'(irq), 64'd1);

        // Nesting
        cycle(1, 0);
        set_slot(1, 6'h20, 32'h40);
        irq_status = 32'h21;
        check("nest_pend");
        cycle(1, 0);
        check("nest_ack");
        chk("nest_insvc_lit", 64'(in_service), 64'h0A);
        set_slot(5, 6'h26, 32'h200);
        irq_status = 32'h61;
        check("nest_lowblk");
        chk("nest_irq_lit", 64'(irq), 64'd0);
        cycle(0, 1);
        check("nest_pop1");
        chk("nest_pop1_lit", 64'(in_service), 64'h08);
        cycle(0, 1);
        check("nest_pop2");

        // Default level
        irq_status = 32'h8000_0000;
        clear_slots();
        check("def_pend");
        cycle(1, 0);
        check("def_ack");
        chk("def_rdata_lit", 64'(va_rdata), 64'hDEAD);
        chk("def_insvc_lit", 64'(in_service), 64'(1 << NV));
        set_slot(2, 6'h21, 32'h300);
        irq_status = 32'h8000_0002;
        check("def_preempt");
        cycle(1, 0);
        check("def_nest");
        cycle(0, 1);
        cycle(0, 1);
        check("def_unwind");

        // Edge cases
        irq_status = '0;
        def_vect_addr = 32'hBEEF;
        cycle(1, 0);
        check("spurious");
        set_slot(3, 6'h25, 32'h100);
        irq_status = 32'h20;
        cycle(1, 0);
        cycle(1, 1);
        check("rdwr_same");
        cycle(0, 1);
        check("wr_empty");

        // Reset mid-service with two levels stacked
        set_slot(1, 6'h20, 32'h40);
        cycle(1, 0);
        irq_status = 32'h21;
        cycle(1, 0);
        check("pre_rst");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stk.delete();
        exp_rdata = '0;
        check("mid_rst");

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0)
                set_slot($urandom_range(0, NV - 1), 6'($urandom), $urandom);
            if ($urandom_range(0, 7) == 0) def_vect_addr = $urandom;
            irq_status = $urandom & $urandom & $urandom;
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
